uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

UART receive front end that turns the serial line into the parallel byte stream consumed by the system controller. It synchronises the line, detects start bits and oversamples each bit with a 3-sample majority vote. It checks optional parity and the stop bit. It presents each good byte as `o_P_DATA` with a one-cycle `o_D_VLD` strobe; these drive the controller's `i_RX_P_DATA` and `i_RX_D_VLD` inputs. It runs entirely in the UART RX clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 8: frame data bits, LSB first.
- `PRESCALE_WIDTH`, 6: width of the oversampling-ratio input.

Ports:
- `i_CLK`, in, 1: oversampling clock. One clock only.
- `i_RST`, in, 1: reset. Asynchronous and active-high.
- `i_RX_IN`, in, 1: serial line; idles high; asynchronous to `i_CLK`.
- `i_Prescale`, in, PRESCALE_WIDTH: oversampling ratio P. Legal values are 8, 16 and 32. It is latched at start detection.
- `i_PAR_EN`, in, 1: a parity bit follows the data. Latched at start detection.
- `i_PAR_TYP`, in, 1: 0 selects even parity, 1 selects odd. Latched at start detection.
- `o_P_DATA`, out, DATA_WIDTH: last good byte. Reset value 0.
- `o_D_VLD`, out, 1: one-cycle strobe meaning `o_P_DATA` is new. Reset value 0.
- `o_PAR_ERR`, out, 1: one-cycle strobe for a parity mismatch. Reset value 0.
- `o_STP_ERR`, out, 1: one-cycle strobe for a stop bit sampled low. Reset value 0.

## Operation
- Synchroniser: `i_RX_IN` passes through 2 flops that reset to 1. The FSM and the samplers see only the synchronised value `rx_s`. All cycle counts below are relative to `rx_s`.
- Counters: `edge_cnt` runs 0..P-1 within a bit. `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- Sampling: `rx_s` is captured at `edge_cnt` = P/2-2, P/2-1 and P/2. The bit value is the majority of the 3 samples and is registered at `edge_cnt` = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when `rx_s`=0, latch P, `i_PAR_EN` and `i_PAR_TYP`. That same cycle is `edge_cnt`=0 of START.
  - START: if the voted bit is 1, treat it as a glitch. Return to IDLE at `edge_cnt`=P/2+1, with no output. Otherwise go to DATA at `edge_cnt`=P-1.
  - DATA: shift the voted bit into the shift register, LSB first. After bit DATA_WIDTH-1, go to PARITY if parity is enabled, else to STOP. Transitions happen at `edge_cnt`=P-1.
  - PARITY: compare the voted bit with the XOR of the data bits, inverted when `i_PAR_TYP`=1. Record any mismatch. Go to STOP at P-1.
  - STOP: at `edge_cnt`=P-1, register the outputs:
    - Stop=1 and no parity error: load `o_P_DATA` and pulse `o_D_VLD`.
    - Parity error: pulse `o_PAR_ERR`. `o_P_DATA` is unchanged.
    - Stop=0: pulse `o_STP_ERR`. This takes priority over a parity error, so `o_PAR_ERR` is also pulsed only if parity failed. `o_P_DATA` is unchanged.
    - Next state is IDLE if stop=1, else WAIT_HIGH.
  - WAIT_HIGH: hold until `rx_s`=1, then go to IDLE. This state blocks false restart during a break.
- `o_D_VLD` and `o_STP_ERR` are never asserted together.
- Input changes on `i_Prescale`, `i_PAR_EN` or `i_PAR_TYP` in mid-frame have no effect on the current frame.
- Reset at any time: FSM returns to IDLE and counters clear. All outputs take their reset values on the next evaluation. A partial frame is discarded.

## Timing
- Start detect cycle = cycle 0. N = 1 + DATA_WIDTH + `i_PAR_EN` + 1 bits per frame.
- `o_D_VLD` and the error strobes are high in cycle N·P after cycle 0, for exactly 1 cycle.
- In that same cycle the FSM is in IDLE and can detect the next start bit. Back-to-back frames are received with no gap.
- `o_P_DATA` holds its value until the next good frame.
- There is no backpressure. The consumer must accept the strobe in the cycle it is asserted.
- End-to-end latency from the `i_RX_IN` edge: add 2 cycles of synchroniser delay.

## Structure
- Package `uart_rx_pkg`:
  - FSM state encoding, with a width constant.
  - Legal prescale constants: 8, 16, 32.
  - A parity-type encoding constant: EVEN=0, ODD=1.
- Sub-module `uart_rx_sampler` contains:
  - `edge_cnt`
  - the 3-sample capture
  - the majority vote
  - `sample_done` / `bit_end` strobes for the FSM.
- The FSM, shift register and parity check live in the top module.

## Test plan
- P=8, no parity, byte 0xA5: `o_P_DATA`=0xA5 and a single `o_D_VLD` pulse at cycle 80. No error strobes.
- P=16, even parity, byte 0x3C with parity bit 0: `o_D_VLD` at cycle 176 with `o_P_DATA`=0x3C.
- Same frame with the parity bit flipped to 1: `o_PAR_ERR` pulse at cycle 176. No `o_D_VLD`; `o_P_DATA` keeps its old value.
- P=8, byte 0x55, stop bit driven 0 and the line held low for 40 cycles: `o_STP_ERR` pulse and no `o_D_VLD`. No new frame starts until the line returns high.
- P=16, line low for 3 cycles then high: no strobes, and the FSM is back in IDLE by cycle 9.
- P=32, odd parity, frames 0x00 then 0xFF back-to-back: two `o_D_VLD` pulses 352 cycles apart with the correct data.
- Reset asserted during DATA of byte 0x81: no strobes, and outputs stay at 0. A following 0x81 frame is then received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

   // FSM state encoding
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;

   // Supported oversampling ratios
   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   // Parity type select
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // 2-of-3 majority of the mid-bit samples
   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, 3-sample mid-bit capture, majority vote
// and the strobes the FSM steps on.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6
)(
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_rx,
   input  logic                      i_cnt_en,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   output logic                      o_vote,
   output logic                      o_bit,
   output logic                      o_sample_done,
   output logic                      o_bit_end
);

   localparam int PW = PRESCALE_WIDTH;

   logic [PW-1:0] edge_cnt_q, edge_cnt_d;
   logic [PW-1:0] half;
   logic [2:0]    samp_q, samp_d;
   logic          bit_q, bit_d;

   assign half          = {1'b0, i_prescale[PW-1:1]};
   assign o_bit_end     = (edge_cnt_q == i_prescale - PW'(1));
   assign o_sample_done = (edge_cnt_q == half + PW'(1));
   assign o_vote        = maj3(samp_q);
   assign o_bit         = bit_q;

   // Next-state: edge counter wraps at P-1, samples taken around mid-bit
   always_comb begin
      edge_cnt_d = '0;
      if (i_cnt_en)
         edge_cnt_d = o_bit_end ? '0 : edge_cnt_q + PW'(1);
      samp_d = samp_q;
      if (edge_cnt_q == half - PW'(2)) samp_d[0] = i_rx;
      if (edge_cnt_q == half - PW'(1)) samp_d[1] = i_rx;
      if (edge_cnt_q == half)          samp_d[2] = i_rx;
      bit_d = o_sample_done ? o_vote : bit_q;
   end

   // Sampler state registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         edge_cnt_q <= '0;
         samp_q     <= 3'b111;
         bit_q      <= 1'b1;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive front end: line synchroniser, frame FSM, shift register,
// parity/stop checking and registered result strobes.
module uart_rx_frame
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
)(
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic                      i_RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] i_Prescale,
   input  logic                      i_PAR_EN,
   input  logic                      i_PAR_TYP,
   output logic [DATA_WIDTH-1:0]     o_P_DATA,
   output logic                      o_D_VLD,
   output logic                      o_PAR_ERR,
   output logic                      o_STP_ERR
);

   localparam int PW  = PRESCALE_WIDTH;
   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [1:0]            sync_q, sync_d;
   logic                  rx_s;
   state_t                state_q, state_d;
   logic [PW-1:0]         prescale_q, prescale_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_bad_q, par_bad_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  d_vld_q, d_vld_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic vote, bit_val, sample_done, bit_end;
   logic busy, abort, cnt_en, prescale_legal;

   assign rx_s = sync_q[1];

   // Counter runs from the start-detect cycle through the stop bit; a
   // rejected start glitch clears it so the next detect begins at zero.
   assign busy   = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_PARITY) || (state_q == ST_STOP);
   assign abort  = (state_q == ST_START) && sample_done && vote;
   assign cnt_en = ((state_q == ST_IDLE) && !rx_s) || (busy && !abort);

   // Unsupported ratios fall back to 16 rather than producing odd timing
   assign prescale_legal = (i_Prescale == PW'(PRESCALE_8))  ||
                           (i_Prescale == PW'(PRESCALE_16)) ||
                           (i_Prescale == PW'(PRESCALE_32));

   uart_rx_sampler #(.PRESCALE_WIDTH(PW)) u_sampler (
      .i_clk         (i_CLK),
      .i_rst         (i_RST),
      .i_rx          (rx_s),
      .i_cnt_en      (cnt_en),
      .i_prescale    (prescale_q),
      .o_vote        (vote),
      .o_bit         (bit_val),
      .o_sample_done (sample_done),
      .o_bit_end     (bit_end)
   );

   // Frame FSM next-state, datapath and result strobes
   always_comb begin
      sync_d     = {sync_q[0], i_RX_IN};
      state_d    = state_q;
      prescale_d = prescale_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      p_data_d   = p_data_q;
      d_vld_d    = 1'b0;
      par_err_d  = 1'b0;
      stp_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d    = ST_START;
               prescale_d = prescale_legal ? i_Prescale : PW'(PRESCALE_16);
               par_en_d   = i_PAR_EN;
               par_typ_d  = i_PAR_TYP;
               bit_cnt_d  = '0;
               par_bad_d  = 1'b0;
            end
         end
         ST_START: begin
            if (abort)        state_d = ST_IDLE;
            else if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == BCW'(DATA_WIDTH-1)) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               par_bad_d = bit_val != ((^shift_q) ^ (par_typ_q == PAR_ODD));
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_val && !par_bad_q) begin
                  p_data_d = shift_q;
                  d_vld_d  = 1'b1;
               end
               par_err_d = par_bad_q;
               stp_err_d = !bit_val;
               state_d   = bit_val ? ST_IDLE : ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame state and output registers
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         sync_q     <= 2'b11;
         state_q    <= ST_IDLE;
         prescale_q <= PW'(PRESCALE_8);
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_bad_q  <= 1'b0;
         p_data_q   <= '0;
         d_vld_q    <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         prescale_q <= prescale_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_bad_q  <= par_bad_d;
         p_data_q   <= p_data_d;
         d_vld_q    <= d_vld_d;
         par_err_q  <= par_err_d;
         stp_err_q  <= stp_err_d;
      end
   end

   assign o_P_DATA  = p_data_q;
   assign o_D_VLD   = d_vld_q;
   assign o_PAR_ERR = par_err_q;
   assign o_STP_ERR = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames plus random frames,
// checked against an event-level model of what each frame should produce.
module tb_uart_rx_frame;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          i_CLK = 1'b0;
   logic          i_RST;
   logic          i_RX_IN;
   logic [PW-1:0] i_Prescale;
   logic          i_PAR_EN;
   logic          i_PAR_TYP;
   logic [DW-1:0] o_P_DATA;
   logic          o_D_VLD;
   logic          o_PAR_ERR;
   logic          o_STP_ERR;

   uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .i_CLK      (i_CLK),
      .i_RST      (i_RST),
      .i_RX_IN    (i_RX_IN),
      .i_Prescale (i_Prescale),
      .i_PAR_EN   (i_PAR_EN),
      .i_PAR_TYP  (i_PAR_TYP),
      .o_P_DATA   (o_P_DATA),
      .o_D_VLD    (o_D_VLD),
      .o_PAR_ERR  (o_PAR_ERR),
      .o_STP_ERR  (o_STP_ERR)
   );

   always #5 i_CLK = ~i_CLK;

   // rising edges seen so far
   int pc = 0;
   always @(posedge i_CLK) pc <= pc + 1;

   typedef struct {
      int            cyc;
      logic [2:0]    flags;   // {vld, par_err, stp_err}
      logic [DW-1:0] data;
   } ev_t;

   ev_t obs_q[$];
   ev_t exp_q[$];
   ev_t mon_ev;

   // log every strobe cycle, sampled mid-cycle
   always @(negedge i_CLK) begin
      if (o_D_VLD || o_PAR_ERR || o_STP_ERR) begin
         mon_ev.cyc   = pc;
         mon_ev.flags = {o_D_VLD, o_PAR_ERR, o_STP_ERR};
         mon_ev.data  = o_P_DATA;
         obs_q.push_back(mon_ev);
      end
   end

   int            vectors    = 0;
   int            miscompares = 0;
   logic [DW-1:0] last_good  = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one frame starting just after a falling edge; records the model's
   // expected outcome. Config inputs are scrambled once the start bit is past.
   task automatic send_frame(input int p, input bit pen, input bit ptyp,
                             input logic [DW-1:0] data, input bit flip_par,
                             input bit stop, input int hold_low, input int gap);
      bit   bits[$];
      ev_t  e;
      int   n;
      bit   par_ok;
      i_Prescale = PW'(p);
      i_PAR_EN   = pen;
      i_PAR_TYP  = ptyp;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(data[i]);
      if (pen) bits.push_back((^data) ^ ptyp ^ flip_par);
      bits.push_back(stop);
      n      = bits.size();
      par_ok = !(pen && flip_par);
      e.cyc   = pc + 2 + n * p;
      e.flags = {stop && par_ok, !par_ok, !stop};
      e.data  = (stop && par_ok) ? data : last_good;
      if (stop && par_ok) last_good = data;
      exp_q.push_back(e);
      for (int k = 0; k < n; k++) begin
         i_RX_IN = bits[k];
         if (k == 1) begin
            i_Prescale = PW'(8 << $urandom_range(0, 2));
            i_PAR_EN   = 1'($urandom);
            i_PAR_TYP  = 1'($urandom);
         end
         repeat (p) @(negedge i_CLK);
      end
      if (hold_low > 0) begin
         i_RX_IN = 1'b0;
         repeat (hold_low) @(negedge i_CLK);
      end
      i_RX_IN = 1'b1;
      repeat (gap) @(negedge i_CLK);
   endtask

   // Let pending strobes land, then compare observed events with the model
   task automatic check_events(input string tag);
      ev_t o, x;
      repeat (6) @(negedge i_CLK);
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         x = exp_q.pop_front();
         chk({tag, "_cycle"}, o.cyc, x.cyc);
         chk({tag, "_flags"}, {29'd0, o.flags}, {29'd0, x.flags});
         chk({tag, "_data"},  {24'd0, o.data},  {24'd0, x.data});
      end
      obs_q.delete();
      exp_q.delete();
      chk({tag, "_pdata_hold"}, {24'd0, o_P_DATA}, {24'd0, last_good});
   endtask

   initial begin
      int  p;
      bit  pen, ptyp, flip, stop;
      logic [DW-1:0] d;

      i_RST      = 1'b1;
      i_RX_IN    = 1'b1;
      i_Prescale = PW'(8);
      i_PAR_EN   = 1'b0;
      i_PAR_TYP  = 1'b0;
      repeat (3) @(negedge i_CLK);
      chk("rst_pdata",   {24'd0, o_P_DATA}, 32'd0);
      chk("rst_dvld",    {31'd0, o_D_VLD},   32'd0);
      chk("rst_parerr",  {31'd0, o_PAR_ERR}, 32'd0);
      chk("rst_stperr",  {31'd0, o_STP_ERR}, 32'd0);
      i_RST = 1'b0;
      repeat (2) @(negedge i_CLK);

      // P=8, no parity, 0xA5
      send_frame(8, 0, 0, 8'hA5, 0, 1, 0, 2);
      check_events("p8_a5");

      // P=16, even parity, 0x3C, good then flipped parity bit
      send_frame(16, 1, 0, 8'h3C, 0, 1, 0, 2);
      check_events("p16_even_ok");
      send_frame(16, 1, 0, 8'h3C, 1, 1, 0, 2);
      check_events("p16_even_bad");

      // P=8, 0x55, stop bit low, break held 40 cycles, then recovery
      send_frame(8, 0, 0, 8'h55, 0, 0, 40, 4);
      check_events("p8_break");
      send_frame(8, 0, 0, 8'h12, 0, 1, 0, 2);
      check_events("p8_after_break");

      // P=16 start glitch of 3 cycles, then a real frame
      i_Prescale = PW'(16);
      i_RX_IN    = 1'b0;
      repeat (3) @(negedge i_CLK);
      i_RX_IN = 1'b1;
      repeat (12) @(negedge i_CLK);
      check_events("p16_glitch");
      send_frame(16, 0, 0, 8'h6B, 0, 1, 0, 2);
      check_events("p16_after_glitch");

      // P=32 odd parity, back-to-back 0x00 then 0xFF
      send_frame(32, 1, 1, 8'h00, 0, 1, 0, 0);
      send_frame(32, 1, 1, 8'hFF, 0, 1, 0, 2);
      check_events("p32_b2b");

      // reset in the middle of data bits of 0x81
      i_Prescale = PW'(8);
      i_PAR_EN   = 1'b0;
      i_RX_IN    = 1'b0;
      repeat (8) @(negedge i_CLK);
      i_RX_IN = 1'b1;
      repeat (8) @(negedge i_CLK);
      i_RX_IN = 1'b0;
      repeat (8) @(negedge i_CLK);
      i_RST   = 1'b1;
      i_RX_IN = 1'b1;
      #1;
      last_good = '0;
      chk("midrst_pdata", {24'd0, o_P_DATA}, 32'd0);
      repeat (10) @(negedge i_CLK);
      i_RST = 1'b0;
      repeat (20) @(negedge i_CLK);
      chk("midrst_dvld", {31'd0, o_D_VLD}, 32'd0);
      check_events("midrst_quiet");
      send_frame(8, 0, 0, 8'h81, 0, 1, 0, 2);
      check_events("midrst_81");

      // random frames
      for (int r = 0; r < 14; r++) begin
         p    = 8 << $urandom_range(0, 2);
         pen  = 1'($urandom);
         ptyp = 1'($urandom);
         d    = DW'($urandom);
         flip = pen && ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(p, pen, ptyp, d, flip, stop,
                    stop ? 0 : int'($urandom_range(0, 20)), 2);
         check_events("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
